// File: rtl/css_boot_seq_pkg.sv
// Shared types and defaults for the Caliptra SS boot/reset sequencer.
// State encodings are visible to software through boot_state_o, so they are fixed here.
package css_boot_seq_pkg;

  typedef enum logic [3:0] {
    BS_IDLE       = 4'h0,
    BS_BRKPT      = 4'h1,
    BS_OTP        = 4'h2,
    BS_LC         = 4'h3,
    BS_CPTRA_HOLD = 4'h4,
    BS_MCU_WAIT   = 4'h5,
    BS_DONE       = 4'h6,
    BS_ERROR      = 4'hF
  } boot_state_e;

  localparam int BOOT_TMO_DEFAULT      = 4096;
  localparam int BOOT_RST_HOLD_DEFAULT = 16;

endpackage

// File: rtl/css_boot_init_hs.sv
// One init handshake: while i_start is high, wait for done/err with an optional timeout.
// Outputs are combinational so the parent FSM leaves the state on the same edge.
module css_boot_init_hs #(
  parameter int TMO_CYCLES = 4096,
  parameter int CNT_W      = 16
) (
  input  logic cptra_ss_clk_i,
  input  logic cptra_ss_rst_b_i,
  input  logic i_start,
  input  logic i_done,
  input  logic i_err,
  output logic o_ok,
  output logic o_fail
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tmo_hit;

  assign w_tmo_hit = (TMO_CYCLES != 0) && (r_cnt == CNT_W'(TMO_CYCLES - 1));

  // err beats done, done beats a timeout landing on the same cycle.
  assign o_ok   = i_start & ~i_err & i_done;
  assign o_fail = i_start & (i_err | (w_tmo_hit & ~i_done));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge cptra_ss_clk_i) begin
    if (!cptra_ss_rst_b_i) begin
      r_cnt <= '0;
    end else if (!i_start) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/css_boot_rst_sequencer_sva.sv
// Protocol properties for the boot sequencer, attached to every instance through bind.
module css_boot_rst_sequencer_sva
  import css_boot_seq_pkg::*;
(
  input logic       cptra_ss_clk_i,
  input logic       cptra_ss_rst_b_i,
  input logic       otp_init_req_o,
  input logic       lc_init_req_o,
  input logic       cptra_rst_b_o,
  input logic       mcu_rst_b_o,
  input logic       fatal_err_o,
  input logic [3:0] boot_state_o
);

  a_req_onehot: assert property (@(posedge cptra_ss_clk_i)
    !(otp_init_req_o && lc_init_req_o));

  a_req_in_state: assert property (@(posedge cptra_ss_clk_i)
    (!otp_init_req_o || boot_state_o == BS_OTP) && (!lc_init_req_o || boot_state_o == BS_LC));

  // Reset outputs may only fall because of a reset or an entry into ERROR.
  a_cptra_mono: assert property (@(posedge cptra_ss_clk_i)
    $fell(cptra_rst_b_o) |-> (!$past(cptra_ss_rst_b_i) || boot_state_o == BS_ERROR));

  a_mcu_mono: assert property (@(posedge cptra_ss_clk_i)
    $fell(mcu_rst_b_o) |-> (!$past(cptra_ss_rst_b_i) || boot_state_o == BS_ERROR));

  a_fatal_sticky: assert property (@(posedge cptra_ss_clk_i)
    ($past(fatal_err_o) && $past(cptra_ss_rst_b_i)) |-> fatal_err_o);

endmodule

bind css_boot_rst_sequencer css_boot_rst_sequencer_sva u_sva (
  .cptra_ss_clk_i   (cptra_ss_clk_i),
  .cptra_ss_rst_b_i (cptra_ss_rst_b_i),
  .otp_init_req_o   (otp_init_req_o),
  .lc_init_req_o    (lc_init_req_o),
  .cptra_rst_b_o    (cptra_rst_b_o),
  .mcu_rst_b_o      (mcu_rst_b_o),
  .fatal_err_o      (fatal_err_o),
  .boot_state_o     (boot_state_o)
);

// File: rtl/css_boot_rst_sequencer.sv
// Caliptra SS boot/reset sequencer: OTP init, LC init, Caliptra reset hold/release,
// then MCU reset release (optionally gated on fw_exec). Sticky fatal on any init failure.
module css_boot_rst_sequencer
  import css_boot_seq_pkg::*;
#(
  parameter int TMO_CYCLES = BOOT_TMO_DEFAULT,
  parameter int RST_HOLD   = BOOT_RST_HOLD_DEFAULT,
  parameter int CNT_W      = 16
) (
  input  logic       cptra_ss_clk_i,
  input  logic       cptra_ss_rst_b_i,
  input  logic       boot_brkpoint_i,
  input  logic       brkpoint_go_i,
  input  logic       no_rom_config_i,
  input  logic       fw_exec_ctrl_2_mcu_i,
  output logic       otp_init_req_o,
  input  logic       otp_init_done_i,
  input  logic       otp_init_err_i,
  output logic       lc_init_req_o,
  input  logic       lc_init_done_i,
  input  logic       lc_init_err_i,
  output logic       cptra_rst_b_o,
  output logic       mcu_rst_b_o,
  output logic       fatal_err_o,
  output logic [3:0] boot_state_o
);

  localparam logic [3:0] ST_IDLE       = BS_IDLE;
  localparam logic [3:0] ST_BRKPT      = BS_BRKPT;
  localparam logic [3:0] ST_OTP        = BS_OTP;
  localparam logic [3:0] ST_LC         = BS_LC;
  localparam logic [3:0] ST_CPTRA_HOLD = BS_CPTRA_HOLD;
  localparam logic [3:0] ST_MCU_WAIT   = BS_MCU_WAIT;
  localparam logic [3:0] ST_DONE       = BS_DONE;
  localparam logic [3:0] ST_ERROR      = BS_ERROR;

  localparam int MAX_CNT = (TMO_CYCLES > RST_HOLD) ? TMO_CYCLES : RST_HOLD;

  if (CNT_W < $clog2(MAX_CNT + 1) || RST_HOLD < 1) begin : g_param_check
    $error("css_boot_rst_sequencer: CNT_W too narrow or RST_HOLD < 1");
  end

  logic [3:0]       r_state;
  logic [3:0]       w_state_nxt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_otp_req;
  logic             r_lc_req;
  logic             r_cptra_rst_b;
  logic             r_mcu_rst_b;
  logic             r_fatal;
  logic             r_no_rom;
  logic             w_otp_ok;
  logic             w_otp_fail;
  logic             w_lc_ok;
  logic             w_lc_fail;
  logic             w_hold_last;

  css_boot_init_hs #(.TMO_CYCLES(TMO_CYCLES), .CNT_W(CNT_W)) u_otp_hs (
    .cptra_ss_clk_i   (cptra_ss_clk_i),
    .cptra_ss_rst_b_i (cptra_ss_rst_b_i),
    .i_start          (r_state == ST_OTP),
    .i_done           (otp_init_done_i),
    .i_err            (otp_init_err_i),
    .o_ok             (w_otp_ok),
    .o_fail           (w_otp_fail)
  );

  css_boot_init_hs #(.TMO_CYCLES(TMO_CYCLES), .CNT_W(CNT_W)) u_lc_hs (
    .cptra_ss_clk_i   (cptra_ss_clk_i),
    .cptra_ss_rst_b_i (cptra_ss_rst_b_i),
    .i_start          (r_state == ST_LC),
    .i_done           (lc_init_done_i),
    .i_err            (lc_init_err_i),
    .o_ok             (w_lc_ok),
    .o_fail           (w_lc_fail)
  );

  assign w_hold_last = (r_hold_cnt == CNT_W'(RST_HOLD - 1));

  // NOTE: the default assignment ahead of the case keeps this block free of latches.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:       w_state_nxt = boot_brkpoint_i ? ST_BRKPT : ST_OTP;
      ST_BRKPT:      if (brkpoint_go_i) w_state_nxt = ST_OTP;
      ST_OTP: begin
        if (w_otp_fail)    w_state_nxt = ST_ERROR;
        else if (w_otp_ok) w_state_nxt = ST_LC;
      end
      ST_LC: begin
        if (w_lc_fail)     w_state_nxt = ST_ERROR;
        else if (w_lc_ok)  w_state_nxt = ST_CPTRA_HOLD;
      end
      ST_CPTRA_HOLD: if (w_hold_last) w_state_nxt = ST_MCU_WAIT;
      ST_MCU_WAIT:   if (!r_no_rom || fw_exec_ctrl_2_mcu_i) w_state_nxt = ST_DONE;
      ST_DONE:       w_state_nxt = ST_DONE;
      ST_ERROR:      w_state_nxt = ST_ERROR;
      default:       w_state_nxt = ST_ERROR;
    endcase
  end

  always_ff @(posedge cptra_ss_clk_i) begin
    if (!cptra_ss_rst_b_i) begin
      r_state       <= ST_IDLE;
      r_hold_cnt    <= '0;
      r_otp_req     <= 1'b0;
      r_lc_req      <= 1'b0;
      r_cptra_rst_b <= 1'b0;
      r_mcu_rst_b   <= 1'b0;
      r_fatal       <= 1'b0;
      r_no_rom      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_otp_req  <= (w_state_nxt == ST_OTP);
      r_lc_req   <= (w_state_nxt == ST_LC);
      r_hold_cnt <= (r_state == ST_CPTRA_HOLD) ? r_hold_cnt + CNT_W'(1) : '0;

      // The strap is captured once, on the edge that enters MCU_WAIT.
      if (w_state_nxt == ST_MCU_WAIT && r_state != ST_MCU_WAIT) begin
        r_no_rom <= no_rom_config_i;
      end

      if (w_state_nxt == ST_ERROR) begin
        r_fatal       <= 1'b1;
        r_cptra_rst_b <= 1'b0;
        r_mcu_rst_b   <= 1'b0;
      end else begin
        if (r_state == ST_CPTRA_HOLD && w_hold_last) r_cptra_rst_b <= 1'b1;
        // MCU release is registered off the DONE state, one edge after entry.
        if (r_state == ST_DONE) r_mcu_rst_b <= 1'b1;
      end
    end
  end

  assign otp_init_req_o = r_otp_req;
  assign lc_init_req_o  = r_lc_req;
  assign cptra_rst_b_o  = r_cptra_rst_b;
  assign mcu_rst_b_o    = r_mcu_rst_b;
  assign fatal_err_o    = r_fatal;
  assign boot_state_o   = r_state;

endmodule
